cell_pos_reader: RTL

Streaming read-side controller for one cell position memory (single-port, 2-cycle read latency, address 0 = particle count, addresses 1..N = {posz, posy, posx}). On `start` it fetches the count, then reads every particle word and presents them in address order on a valid/ready stream toward the force-evaluation pipeline. A credit-limited 4-entry output FIFO absorbs the fixed read latency, so downstream backpressure never drops data.

---
 rtl/cell_pos_reader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cell_pos_reader.sv
// Streams one cell's particle positions out of a 2-cycle-latency memory.
// Reads are credit-limited against a 4-entry FWFT FIFO so backpressure never drops data.
module cell_pos_reader #(
   parameter int DATA_WIDTH   = 96,
   parameter int PARTICLE_NUM = 220,
   parameter int ADDR_WIDTH   = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] count_out,
   output logic                  count_err,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_rden,
   output logic                  mem_wren,
   input  logic [DATA_WIDTH-1:0] mem_q,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_index,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam logic [ADDR_WIDTH-1:0] MAX_CNT  = ADDR_WIDTH'(PARTICLE_NUM - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam int                    DEPTH    = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_RD,
      S_CNT_W1,
      S_CNT_W2,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                r_state;
   logic                  r_busy;
   logic                  r_done;
   logic [ADDR_WIDTH-1:0] r_count;
   logic                  r_err;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [2:0]            r_inflight;

   logic                  r_p0_v;
   logic                  r_p1_v;
   logic [ADDR_WIDTH-1:0] r_p0_idx;
   logic [ADDR_WIDTH-1:0] r_p1_idx;

   logic [DATA_WIDTH-1:0] r_fd [DEPTH];
   logic [ADDR_WIDTH-1:0] r_fi [DEPTH];
   logic [1:0]            r_wp;
   logic [1:0]            r_rp;
   logic [2:0]            r_occ;

   logic                  w_credit;
   logic                  w_issue;
   logic                  w_push;
   logic                  w_pop;
   logic [2:0]            w_occ_next;
   logic                  w_drained;
   logic [ADDR_WIDTH-1:0] w_raw_cnt;
   logic                  w_clamp;

   // Occupancy plus outstanding reads bounds what can still land in the FIFO
   assign w_credit   = ({1'b0, r_occ} + {1'b0, r_inflight}) < 4'd4;
   assign w_issue    = (r_state == S_STREAM) && w_credit;
   assign w_push     = r_p1_v;
   assign w_pop      = (r_occ != 3'd0) && out_ready;
   assign w_occ_next = r_occ + 3'(w_push) - 3'(w_pop);
   assign w_drained  = (r_inflight == 3'd0) && (w_occ_next == 3'd0);
   assign w_raw_cnt  = mem_q[ADDR_WIDTH-1:0];
   assign w_clamp    = w_raw_cnt > MAX_CNT;

   assign busy        = r_busy;
   assign done        = r_done;
   assign count_out   = r_count;
   assign count_err   = r_err;
   assign mem_address = r_addr;
   assign mem_rden    = (r_state == S_CNT_RD) || w_issue;
   assign mem_wren    = 1'b0;
   assign out_valid   = r_occ != 3'd0;
   assign out_data    = r_fd[r_rp];
   assign out_index   = r_fi[r_rp];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_count <= '0;
         r_err   <= 1'b0;
         r_addr  <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_CNT_RD;
                  r_busy  <= 1'b1;
                  r_err   <= 1'b0;
                  r_addr  <= '0;
               end
            end
            S_CNT_RD: r_state <= S_CNT_W1;
            S_CNT_W1: r_state <= S_CNT_W2;
            S_CNT_W2: begin
               r_count <= w_clamp ? MAX_CNT : w_raw_cnt;
               r_err   <= w_clamp;
               if (w_raw_cnt == '0) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_STREAM;
                  r_addr  <= ADDR_ONE;
               end
            end
            S_STREAM: begin
               if (w_issue) begin
                  if (r_addr == r_count) r_state <= S_DRAIN;
                  else                   r_addr  <= r_addr + ADDR_ONE;
               end
            end
            S_DRAIN: begin
               if (w_drained) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Index rides alongside the read so it meets its data at the FIFO
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_p0_v     <= 1'b0;
         r_p1_v     <= 1'b0;
         r_p0_idx   <= '0;
         r_p1_idx   <= '0;
         r_inflight <= '0;
      end else begin
         r_p0_v     <= w_issue;
         r_p0_idx   <= r_addr - ADDR_ONE;
         r_p1_v     <= r_p0_v;
         r_p1_idx   <= r_p0_idx;
         r_inflight <= r_inflight + 3'(w_issue) - 3'(w_push);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_fd[i] <= '0;
            r_fi[i] <= '0;
         end
         r_wp  <= '0;
         r_rp  <= '0;
         r_occ <= '0;
      end else begin
         if (w_push) begin
            r_fd[r_wp] <= mem_q;
            r_fi[r_wp] <= r_p1_idx;
            r_wp       <= r_wp + 2'd1;
         end
         if (w_pop) r_rp <= r_rp + 2'd1;
         r_occ <= w_occ_next;
      end
   end

endmodule
